// File: rtl/fifo_rd_mac_if.sv
// Handshake bundle between fifo_rd_mac, the FIFO read port and the downstream result consumer.
interface fifo_rd_mac_if #(
    parameter int unsigned ACC_W = 40
);
    logic             n_empty;
    logic [63:0]      fifo_dout;
    logic             RE;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;

    modport master (
        input  n_empty, fifo_dout, acc_ready,
        output RE, acc_out, acc_valid
    );

    modport slave (
        output n_empty, fifo_dout, acc_ready,
        input  RE, acc_out, acc_valid
    );
endinterface

// File: rtl/fifo_rd_mac.sv
// FIFO read-side frame dot-product accumulator with valid/ready result output.
// Define MAC_SAT_EN to saturate the accumulator and raise a sticky ovf flag instead of wrapping.
module fifo_rd_mac #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned ACC_W     = 40
) (
    input  logic          clk_out,
    input  logic          rst,
    input  logic          en,
    fifo_rd_mac_if.master bus,
    output logic          busy,
    output logic          ovf
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [7:0] FL = 8'(FRAME_LEN);

    state_t           state;
    logic [7:0]       issue_cnt;
    logic [7:0]       recv_cnt;
    logic             rd_pend;
    logic [ACC_W-1:0] acc;
    logic             acc_valid;
    logic             re;
    logic [31:0]      prod_lo;
    logic [31:0]      prod_hi;
    logic [32:0]      lane_sum;

    assign prod_lo  = {16'd0, bus.fifo_dout[15:0]}  * {16'd0, bus.fifo_dout[31:16]};
    assign prod_hi  = {16'd0, bus.fifo_dout[47:32]} * {16'd0, bus.fifo_dout[63:48]};
    assign lane_sum = {1'b0, prod_lo} + {1'b0, prod_hi};

    // Pop only while the frame still has words left to request; read data lags RE by one cycle.
    assign re = (state == ACCUM) && bus.n_empty && (issue_cnt < FL);

    assign bus.RE        = re;
    assign bus.acc_out   = acc;
    assign bus.acc_valid = acc_valid;
    assign busy          = (state != IDLE);

`ifdef MAC_SAT_EN
    logic             ovf_q;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(lane_sum);
    assign ovf     = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= 1'b0;
            acc       <= '0;
            acc_valid <= 1'b0;
`ifdef MAC_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= ACCUM;
                end
                ACCUM: begin
                    if (re) issue_cnt <= issue_cnt + 8'd1;
                    rd_pend <= re;
                    if (rd_pend) begin
`ifdef MAC_SAT_EN
                        if (ovf_q || acc_sum[ACC_W]) begin
                            acc   <= '1;
                            ovf_q <= 1'b1;
                        end else begin
                            acc <= acc_sum[ACC_W-1:0];
                        end
`else
                        acc <= acc + ACC_W'(lane_sum);
`endif
                        recv_cnt <= recv_cnt + 8'd1;
                        if (recv_cnt + 8'd1 == FL) begin
                            state     <= OUT;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (bus.acc_ready) begin
                        acc_valid <= 1'b0;
                        acc       <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
`ifdef MAC_SAT_EN
                        ovf_q     <= 1'b0;
`endif
                        state     <= en ? ACCUM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_mac.sv
// Bench for fifo_rd_mac: 40-bit and 33-bit instances share stimulus and are checked against a frame-level model.
module tb_fifo_rd_mac;
    localparam int unsigned FL = 4;
    localparam logic [63:0] BASIC = 64'h0005_0004_0003_0002;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, en, n_empty, acc_ready;
    logic [63:0] dout;
    logic        busy40, ovf40, busy33, ovf33;
    int          n_pass = 0;
    int          n_total = 0;
    int          pops = 0;

    always #5 clk = ~clk;

    fifo_rd_mac_if #(.ACC_W(40)) b40 ();
    fifo_rd_mac_if #(.ACC_W(33)) b33 ();

    assign b40.n_empty   = n_empty;
    assign b40.fifo_dout = dout;
    assign b40.acc_ready = acc_ready;
    assign b33.n_empty   = n_empty;
    assign b33.fifo_dout = dout;
    assign b33.acc_ready = acc_ready;

    fifo_rd_mac #(.FRAME_LEN(FL), .ACC_W(40)) u40 (
        .clk_out(clk), .rst(rst), .en(en), .bus(b40.master), .busy(busy40), .ovf(ovf40)
    );
    fifo_rd_mac #(.FRAME_LEN(FL), .ACC_W(33)) u33 (
        .clk_out(clk), .rst(rst), .en(en), .bus(b33.master), .busy(busy33), .ovf(ovf33)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    endtask

    // Frame-level model: a frame is "running" until FL words have arrived, then "holding" until accepted.
    bit          m_run [2];
    bit          m_hold[2];
    bit          m_infl[2];
    int          m_iss [2];
    int          m_rcv [2];
    logic [64:0] m_acc [2];
    bit          m_ovf [2];

    function automatic logic [64:0] max_of(input int k);
        return (65'd1 << (k == 0 ? 40 : 33)) - 65'd1;
    endfunction

    function automatic logic [64:0] dot(input logic [63:0] w);
        return 65'(w[15:0]) * 65'(w[31:16]) + 65'(w[47:32]) * 65'(w[63:48]);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] = 0; m_hold[k] = 0; m_infl[k] = 0;
                m_iss[k] = 0; m_rcv[k] = 0; m_acc[k] = '0; m_ovf[k] = 0;
            end else begin
                bit          want;
                logic [64:0] s;
                want = m_run[k] && n_empty && (m_iss[k] < FL);
                if (m_hold[k]) begin
                    if (acc_ready) begin
                        m_hold[k] = 0; m_run[k] = en;
                        m_iss[k] = 0; m_rcv[k] = 0; m_acc[k] = '0; m_ovf[k] = 0;
                    end
                end else if (m_run[k]) begin
                    if (m_infl[k]) begin
                        s = m_acc[k] + dot(dout);
`ifdef MAC_SAT_EN
                        if (m_ovf[k] || s > max_of(k)) begin
                            m_acc[k] = max_of(k); m_ovf[k] = 1;
                        end else m_acc[k] = s;
`else
                        m_acc[k] = s & max_of(k);
`endif
                        m_rcv[k]++;
                        if (m_rcv[k] == FL) begin
                            m_run[k] = 0; m_hold[k] = 1;
                        end
                    end
                    if (want) m_iss[k]++;
                    m_infl[k] = want;
                end else if (en) begin
                    m_run[k] = 1;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic re, input logic v, input logic [63:0] ao,
                       input logic b, input logic o);
        logic exp_re;
        exp_re = m_run[k] && n_empty && (m_iss[k] < FL);
        chk($sformatf("re[%0d]", k), 64'(re), 64'(exp_re));
        chk($sformatf("acc_valid[%0d]", k), 64'(v), 64'(m_hold[k]));
        chk($sformatf("busy[%0d]", k), 64'(b), 64'(m_run[k] || m_hold[k]));
        chk($sformatf("ovf[%0d]", k), 64'(o), 64'(m_ovf[k]));
        if (m_hold[k]) chk($sformatf("acc_out[%0d]", k), ao, m_acc[k][63:0]);
    endtask

    always @(posedge clk) begin
        #1;
        cmp(0, b40.RE, b40.acc_valid, 64'(b40.acc_out), busy40, ovf40);
        cmp(1, b33.RE, b33.acc_valid, 64'(b33.acc_out), busy33, ovf33);
    end

    always @(posedge clk) if (b40.RE) pops++;

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b40.acc_valid) break;
        end
        chk("valid_timeout", 64'(b40.acc_valid), 64'd1);
    endtask

    task automatic handshake(input logic next_en);
        en = next_en;
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("valid_drop", 64'(b40.acc_valid), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re"},    64'(b40.RE),        64'd0);
        chk({tag, "_valid"}, 64'(b40.acc_valid), 64'd0);
        chk({tag, "_acc"},   64'(b40.acc_out),   64'd0);
        chk({tag, "_busy"},  64'(busy40),        64'd0);
        chk({tag, "_ovf"},   64'(ovf40),         64'd0);
        chk({tag, "_acc33"}, 64'(b33.acc_out),   64'd0);
    endtask

    logic [63:0] tbl [8] = '{64'h0001_0002_0003_0004, 64'h0100_0001_00FF_0002,
                             64'hFFFF_0001_0001_FFFF, 64'h1234_5678_9ABC_DEF0,
                             64'h0000_0000_0007_0009, 64'h8000_8000_8000_8000,
                             64'h0003_0003_0003_0003, 64'hABCD_0000_0000_1111};
    logic [6:0]  pat = 7'b1101001;

    initial begin
        rst = 1'b0; en = 1'b0; n_empty = 1'b0; acc_ready = 1'b0; dout = BASIC;
        #1 rst = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic frame, FIFO never empty
        @(negedge clk);
        en = 1'b1; n_empty = 1'b1; pops = 0;
        wait_valid();
        chk("basic_acc40", 64'(b40.acc_out), 64'd104);
        chk("basic_acc33", 64'(b33.acc_out), 64'd104);
        chk("basic_ovf", 64'(ovf33), 64'd0);
        chk("basic_pops", 64'(pops), 64'd4);

        // Backpressure: result must hold and nothing may be popped
        repeat (10) @(negedge clk);
        chk("bp_valid", 64'(b40.acc_valid), 64'd1);
        chk("bp_acc", 64'(b40.acc_out), 64'd104);
        chk("bp_pops", 64'(pops), 64'd4);
        handshake(1'b1);

        // Empty gaps
        pops = 0;
        for (int i = 0; i < 60 && !b40.acc_valid; i++) begin
            n_empty = pat[i % 7];
            @(negedge clk);
        end
        chk("gap_valid", 64'(b40.acc_valid), 64'd1);
        chk("gap_acc", 64'(b40.acc_out), 64'd104);
        chk("gap_pops", 64'(pops), 64'd4);
        n_empty = 1'b1;
        handshake(1'b0);
        chk("idle_busy", 64'(busy40), 64'd0);

        // All-ones lanes: wrap or saturate in the 33-bit instance
        dout = ONES; en = 1'b1;
        wait_valid();
        chk("ones_acc40", 64'(b40.acc_out), 64'h7_FFF0_0008);
`ifdef MAC_SAT_EN
        chk("ones_acc33", 64'(b33.acc_out), 64'h1_FFFF_FFFF);
        chk("ones_ovf33", 64'(ovf33), 64'd1);
`else
        chk("ones_acc33", 64'(b33.acc_out), 64'h1_FFF0_0008);
        chk("ones_ovf33", 64'(ovf33), 64'd0);
`endif
        chk("ones_ovf40", 64'(ovf40), 64'd0);
        handshake(1'b0);
        chk("ovf_clear", 64'(ovf33), 64'd0);

        // Word-by-word varying data with irregular availability
        en = 1'b1;
        for (int i = 0; i < 60 && !b40.acc_valid; i++) begin
            dout = tbl[i % 8];
            n_empty = (i % 5) != 3;
            @(negedge clk);
        end
        chk("vary_valid", 64'(b40.acc_valid), 64'd1);
        dout = BASIC; n_empty = 1'b1;
        handshake(1'b0);

        // Reset after two words have been accumulated
        @(negedge clk);
        en = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0; pops = 0;
        wait_valid();
        chk("post_rst_acc", 64'(b40.acc_out), 64'd104);
        chk("post_rst_pops", 64'(pops), 64'd4);
        handshake(1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
